// File: rtl/modulo_entrada.sv
// modulo_entrada: input-port peripheral behind the processor's IN instruction.
// Synchronises and debounces the active-low "ent" button, captures the switch
// bank on a confirmed press and holds the word for the CPU until it is read.
module modulo_entrada #(
  parameter int DATA_W     = 16,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] switch,
  input  logic              ent,
  input  logic              rd_req,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              ack
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    FULL      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  // Last count value of a debounce window; the counter never goes past it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic              r_entMeta;
  logic              r_entSync;
  logic [DATA_W-1:0] r_swMeta;
  logic [DATA_W-1:0] r_swSync;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ack;

  state_t            w_nextState;
  logic [CNT_W-1:0]  w_nextCnt;
  logic [DATA_W-1:0] w_nextData;
  logic              w_nextValid;
  logic              w_nextAck;

  // Two-flop synchronisers; the button idles released (1) out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entMeta <= 1'b1;
      r_entSync <= 1'b1;
      r_swMeta  <= '0;
      r_swSync  <= '0;
    end else begin
      r_entMeta <= ent;
      r_entSync <= r_entMeta;
      r_swMeta  <= switch;
      r_swSync  <= r_swMeta;
    end
  end

  // State, debounce counter and the held word / handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_data  <= w_nextData;
      r_valid <= w_nextValid;
      r_ack   <= w_nextAck;
    end
  end

  // Next-state logic: press debounce, hold until read, then release debounce
  // so one physical press can only ever deliver one word.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextData  = r_data;
    w_nextValid = r_valid;
    w_nextAck   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_entSync) begin
          w_nextCnt   = CNT_W'(1);
          w_nextState = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (r_entSync) begin
          w_nextCnt   = '0;
          w_nextState = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_nextData  = r_swSync;
          w_nextValid = 1'b1;
          w_nextCnt   = '0;
          w_nextState = FULL;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      FULL: begin
        if (rd_req) begin
          w_nextValid = 1'b0;
          w_nextAck   = 1'b1;
          w_nextState = DEB_REL;
        end
      end
      DEB_REL: begin
        if (!r_entSync) begin
          w_nextCnt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nextCnt   = '0;
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextCnt   = '0;
        w_nextState = IDLE;
      end
    endcase
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign ack   = r_ack;

endmodule
